// File: rtl/chu_sample_fifo_core.sv
// Periodic sampler: a programmable tick counter captures din into a small FIFO
// that software drains and inspects through the mmio slot registers.
module chu_sample_fifo_core #(
  parameter int unsigned W         = 16,
  parameter int unsigned DEPTH_BIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic [W-1:0] din
);

  localparam int unsigned DEPTH = 2 ** DEPTH_BIT;
  localparam int unsigned PW    = DEPTH_BIT;
  localparam int unsigned CW    = DEPTH_BIT + 1;

  logic [31:0]    period;
  logic           enable;
  logic [31:0]    tick_cnt;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           overflow;
  logic [W-1:0]   mem [DEPTH];

  logic        wr_en;
  logic        wr_period;
  logic        wr_ctrl;
  logic        clr;
  logic        pop_req;
  logic        tick;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push;
  logic        ovf_set;
  logic [15:0] head;
  logic        unused;

  // Slot write decode; addresses 0 and 4..7 are read-only or unmapped.
  assign wr_en     = cs && write;
  assign wr_period = wr_en && (addr[2:0] == 3'd2);
  assign wr_ctrl   = wr_en && (addr[2:0] == 3'd3);
  assign clr       = wr_ctrl && wr_data[1];
  assign pop_req   = wr_en && (addr[2:0] == 3'd1);

  assign tick  = enable && (tick_cnt == period);
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A pop on a full FIFO frees the slot a same-cycle tick needs.
  assign pop     = pop_req && !empty;
  assign push    = tick && (!full || pop);
  assign ovf_set = tick && full && !pop;

  assign unused = ^{read, addr[4:3]};

  always_ff @(posedge clk) begin
    if (reset) begin
      period   <= '0;
      enable   <= 1'b0;
      tick_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_period) period <= wr_data;
      if (wr_ctrl)   enable <= wr_data[0];

      if (clr || !enable || tick) tick_cnt <= '0;
      else                        tick_cnt <= tick_cnt + 32'd1;

      // Clear wins over any same-cycle push or pop.
      if (clr) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
        if (ovf_set) overflow <= 1'b1;
      end
    end
  end

  // Sample storage carries no reset; stale contents are never visible.
  always_ff @(posedge clk) begin
    if (!reset && push && !clr) mem[wr_ptr] <= din;
  end

  assign head = empty ? 16'h0000 : 16'(mem[rd_ptr]);

  always_comb begin
    rd_data = '0;
    case (addr[2:0])
      3'd0:    rd_data = {15'b0, empty, head};
      3'd2:    rd_data = period;
      3'd3:    rd_data = {31'b0, enable};
      3'd4:    rd_data = {13'b0, overflow, full, empty, 16'(count)};
      default: rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_chu_sample_fifo_core.sv
// Directed bench for chu_sample_fifo_core: register vector table plus
// hand-timed sampling, overflow, pop/push, clear and reset sequences.
module tb_chu_sample_fifo_core;

  logic        clk;
  logic        reset;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [15:0] din;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        cs;
    logic        do_wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [31:0] exp;
  } vec_t;

  chu_sample_fifo_core #(.W(16), .DEPTH_BIT(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .din     (din)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // din ramps by one per cycle, changing just after each rising edge.
  initial begin
    din = 16'h0100;
    forever begin
      @(posedge clk);
      #2;
      din = din + 16'd1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic rchk(input string name, input logic [4:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, rd_data, exp);
  endtask

  // One bus write, captured on the next rising edge; returns at the following falling edge.
  task automatic wr(input logic c, input logic [4:0] a, input logic [31:0] d);
    cs      = c;
    write   = 1'b1;
    addr    = a;
    wr_data = d;
    @(negedge clk);
    cs      = 1'b0;
    write   = 1'b0;
    wr_data = '0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  localparam logic [31:0] EMPTY_ST = 32'h0001_0000;

  vec_t        vecs [12];
  logic [15:0] d0;
  logic [15:0] e0;
  logic [15:0] expq [16];

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 5'd2,  32'hDEAD_BEEF, 5'd2,  32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 1'b1, 5'd2,  32'h0000_0005, 5'd2,  32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 1'b1, 5'd5,  32'h1234_5678, 5'd2,  32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 1'b0, 5'd0,  32'h0,         5'd5,  32'h0};
    vecs[4]  = '{1'b1, 1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  EMPTY_ST};
    vecs[5]  = '{1'b1, 1'b1, 5'd4,  32'hFFFF_FFFF, 5'd4,  EMPTY_ST};
    vecs[6]  = '{1'b1, 1'b1, 5'd6,  32'hFFFF_FFFF, 5'd3,  32'h0};
    vecs[7]  = '{1'b1, 1'b1, 5'd7,  32'hFFFF_FFFF, 5'd7,  32'h0};
    vecs[8]  = '{1'b1, 1'b1, 5'd3,  32'hFFFF_FFFE, 5'd3,  32'h0};
    vecs[9]  = '{1'b1, 1'b1, 5'd10, 32'h0000_0007, 5'd2,  32'h0000_0007};
    vecs[10] = '{1'b1, 1'b1, 5'd2,  32'h0,         5'd12, EMPTY_ST};
    vecs[11] = '{1'b1, 1'b0, 5'd0,  32'h0,         5'd6,  32'h0};

    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
    step(3);
    rchk("rst_data", 5'd0, EMPTY_ST);
    rchk("rst_status", 5'd4, EMPTY_ST);
    rchk("rst_period", 5'd2, 32'h0);
    rchk("rst_enable", 5'd3, 32'h0);
    reset = 1'b0;
    step(1);

    // Periodic sampling with period 9: one tick every 10 cycles.
    wr(1'b1, 5'd2, 32'd9);
    d0 = din;
    wr(1'b1, 5'd3, 32'h1);
    rchk("t1_enable", 5'd3, 32'h1);
    step(9);  rchk("t1_cnt_k9",  5'd4, 32'h0001_0000);
    step(1);  rchk("t1_cnt_k10", 5'd4, 32'h0000_0001);
    step(9);  rchk("t1_cnt_k19", 5'd4, 32'h0000_0001);
    step(1);  rchk("t1_cnt_k20", 5'd4, 32'h0000_0002);
    step(9);  rchk("t1_cnt_k29", 5'd4, 32'h0000_0002);
    step(1);  rchk("t1_cnt_k30", 5'd4, 32'h0000_0003);
    wr(1'b1, 5'd3, 32'h0);
    rchk("t1_head0", 5'd0, {16'h0000, 16'(d0 + 16'd10)});
    wr(1'b1, 5'd1, 32'h0);
    rchk("t1_head1", 5'd0, {16'h0000, 16'(d0 + 16'd20)});
    wr(1'b1, 5'd1, 32'h0);
    rchk("t1_head2", 5'd0, {16'h0000, 16'(d0 + 16'd30)});
    wr(1'b1, 5'd1, 32'h0);
    rchk("t1_empty", 5'd0, EMPTY_ST);

    // Register access vectors.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].cs, vecs[i].wa, vecs[i].wd);
      else               step(1);
      rchk($sformatf("vec%0d", i), vecs[i].ra, vecs[i].exp);
    end

    // Overflow: period 0, 20 ticks, no pops.
    wr(1'b1, 5'd2, 32'd0);
    wr(1'b1, 5'd3, 32'h2);
    d0 = din;
    wr(1'b1, 5'd3, 32'h1);
    step(19);
    wr(1'b1, 5'd3, 32'h0);
    rchk("ovf_status", 5'd4, 32'h0006_0010);
    rchk("ovf_head", 5'd0, {16'h0000, 16'(d0 + 16'd1)});

    // Fill exactly 16, then pop on a tick cycle while full.
    wr(1'b1, 5'd3, 32'h2);
    d0 = din;
    wr(1'b1, 5'd3, 32'h1);
    step(15);
    wr(1'b1, 5'd3, 32'h0);
    rchk("full_status", 5'd4, 32'h0002_0010);
    wr(1'b1, 5'd2, 32'd1);
    e0 = din;
    wr(1'b1, 5'd3, 32'h1);
    step(1);
    wr(1'b1, 5'd1, 32'h0);
    wr(1'b1, 5'd3, 32'h0);
    rchk("pp_status", 5'd4, 32'h0002_0010);
    for (int i = 0; i < 15; i++) expq[i] = d0 + 16'(i + 2);
    expq[15] = e0 + 16'd2;
    for (int i = 0; i < 16; i++) begin
      rchk($sformatf("pp_head%0d", i), 5'd0, {16'h0000, expq[i]});
      wr(1'b1, 5'd1, 32'h0);
    end
    rchk("pp_drained", 5'd4, EMPTY_ST);

    // Pop when empty is ignored.
    wr(1'b1, 5'd1, 32'h0);
    rchk("pop_empty_st", 5'd4, EMPTY_ST);
    rchk("pop_empty_data", 5'd0, EMPTY_ST);

    // Clear with count 5 and a coincident tick.
    wr(1'b1, 5'd2, 32'd0);
    wr(1'b1, 5'd3, 32'h1);
    step(5);
    rchk("clr_pre", 5'd4, 32'h0000_0005);
    wr(1'b1, 5'd3, 32'h2);
    rchk("clr_status", 5'd4, EMPTY_ST);
    rchk("clr_data", 5'd0, EMPTY_ST);
    rchk("clr_enable", 5'd3, 32'h0);
    step(3);
    rchk("clr_idle", 5'd4, EMPTY_ST);

    // Reset mid-operation with count 7 and enable set.
    wr(1'b1, 5'd2, 32'd0);
    wr(1'b1, 5'd3, 32'h1);
    step(7);
    rchk("rst7_pre", 5'd4, 32'h0000_0007);
    reset = 1'b1;
    step(1);
    rchk("rst7_data", 5'd0, EMPTY_ST);
    rchk("rst7_status", 5'd4, EMPTY_ST);
    rchk("rst7_period", 5'd2, 32'h0);
    rchk("rst7_enable", 5'd3, 32'h0);
    reset = 1'b0;
    step(5);
    rchk("rst7_noticks", 5'd4, EMPTY_ST);
    wr(1'b1, 5'd3, 32'h1);
    step(3);
    rchk("rst7_reenable", 5'd4, 32'h0000_0003);
    wr(1'b1, 5'd3, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chu_sample_fifo_core.md
CHU_SAMPLE_FIFO_CORE -- requirements
Module: chu_sample_fifo_core

Interface
REQ-001 Parameter W, default 16, sample width in bits (1..16).
REQ-002 Parameter DEPTH_BIT, default 4; the FIFO depth SHALL be 2^DEPTH_BIT entries.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cs  input  1  slot chip select from the mmio controller.
REQ-006 read  input  1  slot read strobe.
REQ-007 write  input  1  slot write strobe.
REQ-008 addr  input  5  slot register address.
REQ-009 wr_data  input  32  slot write data.
REQ-010 rd_data  output  32  slot read data.
REQ-011 din  input  W  external sample source, e.g. the adsr envelope or a pwm/xadc value.

Function
REQ-012 A write SHALL be decoded as cs && write; register selection SHALL use addr[2:0].
REQ-013 Address 2 (write) SHALL load the 32-bit period register from wr_data.
REQ-014 Address 3 (write) SHALL decode wr_data as follows:
- bit0 loads the enable register.
- bit1 = 1 issues a one-cycle clear pulse; the pulse SHALL NOT be stored.
REQ-015 Address 1 (write, any data) SHALL pop the FIFO head; a pop when empty SHALL be ignored.
REQ-016 Tick counter behaviour:
- While enable = 1, a 32-bit counter SHALL count 0..period.
- When count == period, a tick SHALL be asserted and the counter SHALL return to 0.
- period = 0 SHALL tick every cycle.
- While enable = 0, the counter SHALL be held at 0.
REQ-017 On a tick, din SHALL be sampled in that cycle and written to the FIFO tail; it SHALL be readable on the following cycle.
REQ-018 A tick while the FIFO is full with no pop in that cycle SHALL discard the sample and set the sticky overflow flag.
REQ-019 A pop and a push in the same cycle SHALL both take effect with the count unchanged. This applies when full, with no overflow set, and when empty is excluded: an empty FIFO with a push and a pop in the same cycle SHALL take the push only.
REQ-020 Read and write pointers SHALL wrap modulo 2^DEPTH_BIT; the count SHALL be DEPTH_BIT+1 bits and range 0..2^DEPTH_BIT.
REQ-021 The clear pulse SHALL:
- zero the pointers, the count and the overflow flag;
- restart the tick counter at 0;
- take priority over any push or pop in the same cycle.
REQ-022 rd_data SHALL be a combinational mux on addr[2:0], with no read side effects:
- addr 0: {15'b0, empty, head data zero-extended to 16 bits}; head data SHALL be 0 when empty.
- addr 4: {zeros, overflow at bit 18, full at bit 17, empty at bit 16, count in bits [DEPTH_BIT:0]}.
- addr 2: the period register.
- addr 3: {31'b0, enable}.
- all other addresses: 0.
REQ-023 Writes to addresses 0, 4, 5, 6 and 7 SHALL have no effect.

Reset
REQ-024 While reset = 1:
- period, enable, tick counter, pointers, count and overflow SHALL be 0;
- empty SHALL be 1 and full SHALL be 0;
- FIFO storage content is don't-care.
REQ-025 Reset SHALL abort any sampling in progress, and the first tick after reset SHALL require a fresh enable write.

Verification
REQ-026 Periodic sampling and in-order pop:
- Stimulus: period = 9, enable = 1, din ramping by 1 each cycle.
- Response: ticks exactly every 10 cycles; addr 4 count increments by 1 per tick; addr 0 data follows the FIFO order of the captured din values on successive pops.
REQ-027 Overflow with DEPTH_BIT = 4, period = 0:
- Stimulus: enable for 20 cycles with no pops.
- Response: count = 16, full = 1, overflow = 1; the head equals the first sample taken; samples 17..20 are lost.
REQ-028 Simultaneous pop and push:
- Stimulus: with the FIFO full, pop on a tick cycle.
- Response: count stays 16, overflow stays 0, the new sample lands at the tail.
REQ-029 Empty handling:
- Stimulus: pop when empty.
- Response: count 0, empty = 1, addr 0 reads 0x0001_0000.
- Stimulus: clear while count = 5 and a tick is coincident.
- Response: next cycle count = 0, empty = 1, overflow = 0.
REQ-030 Reset mid-operation:
- Stimulus: assert reset with count = 7 and enable = 1.
- Response: next cycle all registers read 0 except empty = 1; no ticks occur until enable is rewritten.
